// File: rtl/vend_pkg.sv
// Shared vending definitions: coin codes, coin values and the change dispenser state encoding.
package vend_pkg;

  localparam int VEND_W = 7;

  localparam logic [1:0] COIN_1  = 2'b00;
  localparam logic [1:0] COIN_2  = 2'b01;
  localparam logic [1:0] COIN_10 = 2'b10;
  localparam logic [1:0] COIN_20 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_ISSUE,
    ST_DONE,
    ST_SHORT
  } disp_state_t;

  function automatic logic [VEND_W-1:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_1:  return VEND_W'(1);
      COIN_2:  return VEND_W'(2);
      COIN_10: return VEND_W'(10);
      default: return VEND_W'(20);
    endcase
  endfunction

endpackage

// File: rtl/coin_select.sv
// Greedy coin picker: largest denomination that fits in the remaining amount and is in stock.
module coin_select
  import vend_pkg::*;
#(
  parameter int W       = 7,
  parameter int STOCK_W = 6
) (
  input  logic [W-1:0]              remaining,
  input  logic [3:0][STOCK_W-1:0]   stock,
  output logic                      found,
  output logic [1:0]                code
);

  // Codes ascend with value, so a later hit in the scan wins the priority.
  always_comb begin
    found = 1'b0;
    code  = COIN_1;
    for (int i = 0; i < 4; i++) begin
      if ((stock[i] != '0) && (W'(coin_value(2'(i))) <= remaining)) begin
        found = 1'b1;
        code  = 2'(i);
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays a refund greedily one coin per hopper handshake from per-coin stock.
//
//  state  | meaning
//  IDLE   | waiting for start; stock may be reloaded
//  SELECT | choose the next coin from remaining and stock
//  ISSUE  | coin presented to hopper until coin_ack
//  DONE   | full amount paid, done pulse
//  SHORT  | no coin fits, short_chg pulse, remaining keeps unpaid value
module change_dispenser
  import vend_pkg::*;
#(
  parameter int W          = 7,
  parameter int STOCK_W    = 6,
  parameter int INIT_STOCK = 20
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic [W-1:0]       amount,
  input  logic               stock_ld,
  input  logic [1:0]         stock_sel,
  input  logic [STOCK_W-1:0] stock_val,
  input  logic               coin_ack,
  output logic               coin_valid,
  output logic [1:0]         coin_sel,
  output logic               busy,
  output logic               done,
  output logic               short_chg,
  output logic [W-1:0]       remaining,
  output logic [3:0]         stock_empty
);

  disp_state_t             state;
  logic [3:0][STOCK_W-1:0] stock;
  logic                    pick_found;
  logic [1:0]              pick_code;
  logic [W-1:0]            coin_amt;
  logic [W-1:0]            rem_next;

  coin_select #(
    .W       (W),
    .STOCK_W (STOCK_W)
  ) u_coin_select (
    .remaining (remaining),
    .stock     (stock),
    .found     (pick_found),
    .code      (pick_code)
  );

  assign coin_amt = W'(coin_value(coin_sel));
  assign rem_next = remaining - coin_amt;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      stock_empty[i] = (stock[i] == '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      coin_valid <= 1'b0;
      coin_sel   <= COIN_1;
      busy       <= 1'b0;
      done       <= 1'b0;
      short_chg  <= 1'b0;
      remaining  <= '0;
      for (int i = 0; i < 4; i++) begin
        stock[i] <= STOCK_W'(INIT_STOCK);
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (stock_ld) begin
            stock[stock_sel] <= stock_val;
          end
          if (start) begin
            remaining <= amount;
            busy      <= 1'b1;
            if (amount == '0) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              state <= ST_SELECT;
            end
          end
        end
        ST_SELECT: begin
          if (pick_found) begin
            coin_sel   <= pick_code;
            coin_valid <= 1'b1;
            state      <= ST_ISSUE;
          end else begin
            short_chg <= 1'b1;
            state     <= ST_SHORT;
          end
        end
        ST_ISSUE: begin
          if (coin_ack) begin
            coin_valid      <= 1'b0;
            remaining       <= rem_next;
            stock[coin_sel] <= stock[coin_sel] - STOCK_W'(1);
            if (rem_next == '0) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              state <= ST_SELECT;
            end
          end
        end
        ST_DONE, ST_SHORT: begin
          done      <= 1'b0;
          short_chg <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          coin_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser against a greedy payout model with per-coin stock.
module tb_change_dispenser;

  logic       CLK = 1'b0;
  logic       RST;
  logic       start;
  logic [6:0] amount;
  logic       stock_ld;
  logic [1:0] stock_sel;
  logic [5:0] stock_val;
  logic       coin_ack;
  logic       coin_valid;
  logic [1:0] coin_sel;
  logic       busy;
  logic       done;
  logic       short_chg;
  logic [6:0] remaining;
  logic [3:0] stock_empty;

  int tests_run = 0;
  int tests_failed = 0;

  int mstock[4];
  int coin_val[4] = '{1, 2, 10, 20};

  change_dispenser dut (
    .CLK         (CLK),
    .RST         (RST),
    .start       (start),
    .amount      (amount),
    .stock_ld    (stock_ld),
    .stock_sel   (stock_sel),
    .stock_val   (stock_val),
    .coin_ack    (coin_ack),
    .coin_valid  (coin_valid),
    .coin_sel    (coin_sel),
    .busy        (busy),
    .done        (done),
    .short_chg   (short_chg),
    .remaining   (remaining),
    .stock_empty (stock_empty)
  );

  always #5 CLK = ~CLK;

  function automatic logic [3:0] model_empty();
    logic [3:0] e;
    for (int i = 0; i < 4; i++) e[i] = (mstock[i] == 0);
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mstock[i] = 20;
  endtask

  task automatic load_stock(input int sel, input int val);
    @(negedge CLK);
    stock_ld = 1'b1; stock_sel = 2'(sel); stock_val = 6'(val);
    @(negedge CLK);
    stock_ld = 1'b0;
    mstock[sel] = val;
  endtask

  // Start a payout, act as hopper, and compare against a greedy model.
  task automatic payout(input string name, input int amt, input int minw, input int maxw,
                        input bit poke, input bit with_ld, input int ld_sel, input int ld_val);
    int exp_coins[$];
    int got_coins[$];
    int rem, rem_exp, ndone, nshort, wait_n, cur, best;
    bit prev_v, finished;
    @(negedge CLK);
    start = 1'b1; amount = 7'(amt);
    if (with_ld) begin
      stock_ld = 1'b1; stock_sel = 2'(ld_sel); stock_val = 6'(ld_val);
      mstock[ld_sel] = ld_val;
    end
    rem = amt;
    forever begin
      best = -1;
      for (int i = 0; i < 4; i++) if (mstock[i] > 0 && coin_val[i] <= rem) best = i;
      if (best < 0) break;
      exp_coins.push_back(best);
      rem -= coin_val[best];
      mstock[best]--;
    end
    rem_exp = amt; ndone = 0; nshort = 0; prev_v = 0; wait_n = 0; cur = 0; finished = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge CLK);
      start = 1'b0; stock_ld = 1'b0; coin_ack = 1'b0;
      if (c == 0) begin
        tests_run++;
        if (busy !== 1'b1) begin
          tests_failed++; $display("FAIL %s busy_after_start: got %b want 1", name, busy);
        end
      end
      if (done) ndone++;
      if (short_chg) nshort++;
      if (!busy) begin finished = 1; break; end
      tests_run++;
      if (remaining !== 7'(rem_exp)) begin
        tests_failed++; $display("FAIL %s remaining_during: got %0d want %0d", name, remaining, rem_exp);
      end
      if (coin_valid) begin
        if (!prev_v) begin
          wait_n = $urandom_range(maxw, minw); cur = coin_sel;
        end else begin
          tests_run++;
          if (coin_sel !== 2'(cur)) begin
            tests_failed++; $display("FAIL %s coin_sel_stable: got %0d want %0d", name, coin_sel, cur);
          end
        end
        if (wait_n == 0) begin
          coin_ack = 1'b1;
          got_coins.push_back(int'(coin_sel));
          rem_exp -= coin_val[coin_sel];
        end else begin
          wait_n--;
        end
      end else if ($urandom_range(3, 0) == 0) begin
        coin_ack = 1'b1;
      end
      prev_v = coin_valid;
      if (poke && busy) begin
        start = 1'b1; amount = 7'($urandom_range(127, 1));
        stock_ld = 1'b1; stock_sel = 2'($urandom_range(3, 0)); stock_val = 6'($urandom_range(63, 0));
      end
    end
    start = 1'b0; stock_ld = 1'b0; coin_ack = 1'b0;
    tests_run++;
    if (!finished) begin
      tests_failed++; $display("FAIL %s timeout: busy still %b want 0", name, busy);
    end
    tests_run++;
    if (got_coins.size() != exp_coins.size()) begin
      tests_failed++; $display("FAIL %s coin_count: got %0d want %0d", name, got_coins.size(), exp_coins.size());
    end else begin
      for (int i = 0; i < exp_coins.size(); i++) begin
        tests_run++;
        if (got_coins[i] != exp_coins[i]) begin
          tests_failed++; $display("FAIL %s coin[%0d]: got code %0d want %0d", name, i, got_coins[i], exp_coins[i]);
        end
      end
    end
    tests_run++;
    if (ndone != ((rem == 0) ? 1 : 0)) begin
      tests_failed++; $display("FAIL %s done_pulses: got %0d want %0d", name, ndone, (rem == 0));
    end
    tests_run++;
    if (nshort != ((rem != 0) ? 1 : 0)) begin
      tests_failed++; $display("FAIL %s short_pulses: got %0d want %0d", name, nshort, (rem != 0));
    end
    tests_run++;
    if (remaining !== 7'(rem)) begin
      tests_failed++; $display("FAIL %s remaining_final: got %0d want %0d", name, remaining, rem);
    end
    tests_run++;
    if (stock_empty !== model_empty()) begin
      tests_failed++; $display("FAIL %s stock_empty: got %b want %b", name, stock_empty, model_empty());
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    model_reset();
    tests_run++;
    if ({coin_valid, busy, done, short_chg} !== 4'b0000 || remaining !== 7'd0 ||
        coin_sel !== 2'd0 || stock_empty !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_state: got v%b b%b d%b s%b sel%0d rem%0d empty%b want all zero",
               coin_valid, busy, done, short_chg, coin_sel, remaining, stock_empty);
    end
  endtask

  task automatic test_directed();
    payout("full_33", 33, 0, 0, 0, 0, 0, 0);
    load_stock(3, 1);
    payout("one_20_40", 40, 0, 0, 0, 0, 0, 0);
    load_stock(0, 0);
    load_stock(1, 1);
    payout("short_3", 3, 0, 0, 0, 0, 0, 0);
    test_reset();
    payout("slow_ack_12", 12, 5, 5, 0, 0, 0, 0);
  endtask

  task automatic test_mid_reset();
    int seen;
    bit hit;
    @(negedge CLK);
    start = 1'b1; amount = 7'd50;
    @(negedge CLK);
    start = 1'b0;
    seen = 0; hit = 0;
    for (int c = 0; c < 40; c++) begin
      if (coin_valid) begin
        seen++;
        if (seen == 2) begin hit = 1; break; end
        coin_ack = 1'b1;
      end
      @(negedge CLK);
      coin_ack = 1'b0;
    end
    tests_run++;
    if (!hit) begin
      tests_failed++; $display("FAIL mid_reset_reach_issue: got %0d coins want 2", seen);
    end
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    tests_run++;
    if (coin_valid !== 1'b0 || busy !== 1'b0 || remaining !== 7'd0 || stock_empty !== 4'b0000) begin
      tests_failed++;
      $display("FAIL mid_reset_state: got v%b b%b rem%0d empty%b want 0 0 0 0000",
               coin_valid, busy, remaining, stock_empty);
    end
    payout("after_reset_127", 127, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic test_zero_and_busy();
    payout("zero_amount", 0, 0, 0, 0, 0, 0, 0);
    payout("poke_while_busy", 57, 0, 2, 1, 0, 0, 0);
    payout("ld_with_start", 22, 0, 1, 0, 1, 3, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(2, 0) == 0) load_stock($urandom_range(3, 0), $urandom_range(4, 0));
      payout("random", $urandom_range(127, 0), 0, 2, $urandom_range(1, 0), $urandom_range(1, 0),
             $urandom_range(3, 0), $urandom_range(6, 0));
    end
  endtask

  initial begin
    start = 1'b0; amount = '0; stock_ld = 1'b0; stock_sel = '0; stock_val = '0; coin_ack = 1'b0;
    RST = 1'b1;
    test_reset();
    test_directed();
    test_mid_reset();
    test_zero_and_busy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
